// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: 2-entry skid buffer (head + skid) with valid/ready on both sides,
// synchronous flush, saturating flush-drop counter and bubble gating of memory/branch controls.
module ex_mem_stage #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_alu_result,
    input  logic [DW-1:0]   in_rd,
    input  logic            in_zero,
    input  logic            in_branch,
    input  logic            in_mw,
    input  logic            in_mr,
    input  logic [RW-1:0]   in_wreg,
    input  logic            in_reg_write,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_alu_result,
    output logic [DW-1:0]   out_rd,
    output logic            out_zero,
    output logic            out_branch,
    output logic            out_mw,
    output logic            out_mr,
    output logic [RW-1:0]   out_wreg,
    output logic            out_reg_write,
    output logic [1:0]      occupancy,
    output logic [CNTW-1:0] flush_drops
);
    localparam int BW = 2*DW + RW + 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   head_q, head_d;
    logic [BW-1:0]   skid_q, skid_d;
    logic [BW-1:0]   in_beat;
    logic [CNTW-1:0] drops_q, drops_d;
    logic [CNTW:0]   drops_sum;
    logic [1:0]      kill_cnt;
    logic            accept, pop;
    logic            head_branch, head_mw, head_mr, head_reg_write;

    assign in_beat = {in_alu_result, in_rd, in_zero, in_branch, in_mw, in_mr, in_wreg, in_reg_write};

    // Handshake decoded purely from state so in_ready has no path from out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = in_beat;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_d = FULL;
                    skid_d  = in_beat;
                end else if (accept && pop) begin
                    head_d  = in_beat;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush kills everything held plus any beat accepted this cycle.
        if (flush) begin
            state_d = EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
        end
    end

    // Beats killed = held + accepted - delivered; never negative since pop implies occupancy>0.
    always_comb begin
        kill_cnt  = occupancy + {1'b0, accept} - {1'b0, pop};
        drops_sum = {1'b0, drops_q} + {{(CNTW-1){1'b0}}, kill_cnt};
        drops_d   = drops_q;
        if (flush) begin
            drops_d = drops_sum[CNTW] ? {CNTW{1'b1}} : drops_sum[CNTW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            drops_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            drops_q <= drops_d;
        end
    end

    assign {out_alu_result, out_rd, out_zero, head_branch, head_mw, head_mr,
            out_wreg, head_reg_write} = head_q;

    // Side-effecting controls are masked during bubbles; stale data is harmless.
    assign out_branch    = head_branch    & out_valid;
    assign out_mw        = head_mw        & out_valid;
    assign out_mr        = head_mr        & out_valid;
    assign out_reg_write = head_reg_write & out_valid;
    assign flush_drops   = drops_q;

endmodule
